// File: rtl/midi_framer.sv
// -----------------------------------------------------------------------------
// midi_framer
//   Assembles a received MIDI byte stream into complete channel messages.
//   Handles running status, 1-byte (0xCn/0xDn) and 2-byte channel messages,
//   ignores realtime bytes, and drops sysex/system traffic. Completed events
//   are held on the outputs until acknowledged. A new event arriving while
//   one is still held is dropped, and rx_overrun pulses.
//
// Ports
//   clk               : clock, all logic on rising edge
//   rst               : synchronous active-high reset
//   rx_data[7:0]      : received byte, qualified by rx_valid
//   rx_valid          : one-cycle strobe per received byte
//   midi_event_ack    : consumer takes the held event
//   midi_event_valid  : an event is held on the outputs
//   midi_command[7:0] : status byte of the held event
//   midi_parameter_1  : first data byte
//   midi_parameter_2  : second data byte (0 for 1-data-byte messages)
//   rx_overrun        : one-cycle pulse when a completed event is dropped
// -----------------------------------------------------------------------------
module midi_framer #(
   parameter bit         VEL0_IS_OFF    = 1'b1,
   parameter bit         CHAN_FILTER_EN = 1'b0,
   parameter logic [3:0] CHANNEL        = 4'd0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   input  logic       midi_event_ack,
   output logic       midi_event_valid,
   output logic [7:0] midi_command,
   output logic [6:0] midi_parameter_1,
   output logic [6:0] midi_parameter_2,
   output logic       rx_overrun
);

   typedef enum logic [1:0] {IDLE, WAIT_P1, WAIT_P2} state_t;

   state_t     state_q;
   logic [7:0] rs_q;        // running status byte
   logic [6:0] p1_q;        // first data byte of a 2-byte message
   logic       valid_q;
   logic [7:0] cmd_q;
   logic [6:0] par1_q;
   logic [6:0] par2_q;
   logic       ovr_q;

   logic       one_byte;    // 0xCn / 0xDn carry a single data byte
   logic       done_d;
   logic       pass_d;
   logic       emit_d;
   logic [7:0] cmd_d;
   logic [6:0] par1_d;
   logic [6:0] par2_d;

   assign one_byte = (rs_q[7:5] == 3'b110);

   // Completion detection and the event that would be loaded this cycle.
   always_comb begin
      done_d = 1'b0;
      cmd_d  = rs_q;
      par1_d = rx_data[6:0];
      par2_d = 7'd0;
      if (rx_valid && !rx_data[7]) begin
         if (state_q == WAIT_P1 && one_byte) begin
            done_d = 1'b1;
         end else if (state_q == WAIT_P2) begin
            done_d = 1'b1;
            par1_d = p1_q;
            par2_d = rx_data[6:0];
         end
      end
      // Note-on with zero velocity is reported as note-off.
      if (VEL0_IS_OFF && rs_q[7:4] == 4'h9 && par2_d == 7'd0)
         cmd_d = {4'h8, rs_q[3:0]};
      pass_d = !CHAN_FILTER_EN || (rs_q[3:0] == CHANNEL);
   end

   assign emit_d = done_d && pass_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         rs_q    <= 8'h00;
         p1_q    <= 7'd0;
         valid_q <= 1'b0;
         cmd_q   <= 8'h00;
         par1_q  <= 7'd0;
         par2_q  <= 7'd0;
         ovr_q   <= 1'b0;
      end else begin
         // Output holding register
         ovr_q <= 1'b0;
         if (valid_q && midi_event_ack)
            valid_q <= 1'b0;
         if (emit_d) begin
            // Load when empty or when the held event leaves this same cycle.
            if (!valid_q || midi_event_ack) begin
               valid_q <= 1'b1;
               cmd_q   <= cmd_d;
               par1_q  <= par1_d;
               par2_q  <= par2_d;
            end else begin
               ovr_q   <= 1'b1;
            end
         end

         // Parser advances independently of output backpressure.
         if (rx_valid) begin
            if (!rx_data[7]) begin
               case (state_q)
                  WAIT_P1: begin
                     p1_q <= rx_data[6:0];
                     if (!one_byte)
                        state_q <= WAIT_P2;
                  end
                  WAIT_P2: state_q <= WAIT_P1;
                  default: ;   // IDLE: no running status, byte discarded
               endcase
            end else if (rx_data[7:4] != 4'hF) begin
               rs_q    <= rx_data;
               state_q <= WAIT_P1;
            end else if (!rx_data[3]) begin
               // System/sysex cancels running status; realtime (0xF8+) falls through.
               rs_q    <= 8'h00;
               state_q <= IDLE;
            end
         end
      end
   end

   assign midi_event_valid = valid_q;
   assign midi_command     = cmd_q;
   assign midi_parameter_1 = par1_q;
   assign midi_parameter_2 = par2_q;
   assign rx_overrun       = ovr_q;

endmodule

// File: tb/tb_midi_framer.sv
// -----------------------------------------------------------------------------
// tb_midi_framer
//   Two framers share one byte stream: u0 with default parameters, u1 with
//   VEL0_IS_OFF=0, CHAN_FILTER_EN=1, CHANNEL=3. A message-level reference
//   model (running status + list of collected data bytes) predicts events,
//   holds and drops for each configuration.
// -----------------------------------------------------------------------------
module tb_midi_framer;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] rx_data = 8'h00;
   logic       rx_valid = 1'b0;
   logic       ack = 1'b0;

   logic       v0, v1, o0, o1;
   logic [7:0] c0, c1;
   logic [6:0] a0, a1, b0, b1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   midi_framer #(.VEL0_IS_OFF(1'b1), .CHAN_FILTER_EN(1'b0), .CHANNEL(4'd0)) u0 (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
      .midi_event_ack(ack), .midi_event_valid(v0), .midi_command(c0),
      .midi_parameter_1(a0), .midi_parameter_2(b0), .rx_overrun(o0));

   midi_framer #(.VEL0_IS_OFF(1'b0), .CHAN_FILTER_EN(1'b1), .CHANNEL(4'd3)) u1 (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
      .midi_event_ack(ack), .midi_event_valid(v1), .midi_command(c1),
      .midi_parameter_1(a1), .midi_parameter_2(b1), .rx_overrun(o1));

   // ---------------- reference model ----------------
   logic [7:0]  m_rs;
   logic [6:0]  m_buf[$];
   logic        m_hv[2];
   logic [21:0] m_hold[2];
   logic        m_op[2];
   int          m_ovr[2];
   logic [21:0] m_log0[$], m_log1[$];
   // DUT-side observations
   logic [21:0] d_log0[$], d_log1[$];
   int          d_ovr0, d_ovr1;

   task automatic model_edge(input logic v, input logic [7:0] d, input logic a, input logic r);
      logic       done;
      logic       keep;
      logic       acc;
      logic [7:0] cmd, oc;
      logic [6:0] p1, p2;
      int         need;
      done = 1'b0; cmd = 8'h00; p1 = 7'd0; p2 = 7'd0;
      if (r) begin
         m_rs = 8'h00;
         m_buf.delete();
         for (int c = 0; c < 2; c++) begin
            m_hv[c] = 1'b0; m_hold[c] = '0; m_op[c] = 1'b0;
         end
      end else begin
         if (v) begin
            if (d >= 8'hF8) begin
               // realtime: no effect
            end else if (d >= 8'hF0) begin
               m_rs = 8'h00; m_buf.delete();
            end else if (d >= 8'h80) begin
               m_rs = d; m_buf.delete();
            end else if (m_rs != 8'h00) begin
               m_buf.push_back(d[6:0]);
               need = (m_rs[7:4] == 4'hC || m_rs[7:4] == 4'hD) ? 1 : 2;
               if (m_buf.size() == need) begin
                  done = 1'b1;
                  cmd  = m_rs;
                  p1   = m_buf[0];
                  p2   = (need == 2) ? m_buf[1] : 7'd0;
                  m_buf.delete();
               end
            end
         end
         for (int c = 0; c < 2; c++) begin
            oc   = cmd;
            keep = done;
            if (c == 0 && done && cmd[7:4] == 4'h9 && p2 == 7'd0) oc = {4'h8, cmd[3:0]};
            if (c == 1) keep = done && (cmd[3:0] == 4'd3);
            acc = m_hv[c] && a;
            m_op[c] = 1'b0;
            if (acc) begin
               if (c == 0) m_log0.push_back(m_hold[c]); else m_log1.push_back(m_hold[c]);
            end
            if (keep) begin
               if (!m_hv[c] || a) begin
                  m_hold[c] = {oc, p1, p2};
                  m_hv[c]   = 1'b1;
               end else begin
                  m_ovr[c]++;
                  m_op[c] = 1'b1;
               end
            end else if (acc) begin
               m_hv[c] = 1'b0;
            end
         end
      end
   endtask

   // One clock: drive inputs, log what the DUTs present before the edge,
   // advance the model, then return 1 time unit after the edge.
   task automatic step(input logic v, input logic [7:0] d, input logic a, input logic r);
      rx_valid = v; rx_data = d; ack = a; rst = r;
      if (!r && v0 === 1'b1 && a) d_log0.push_back({c0, a0, b0});
      if (!r && v1 === 1'b1 && a) d_log1.push_back({c1, a1, b1});
      if (o0 === 1'b1) d_ovr0++;
      if (o1 === 1'b1) d_ovr1++;
      model_edge(v, d, a, r);
      @(posedge clk); #1;
   endtask

   task automatic clear_logs();
      m_log0.delete(); m_log1.delete(); d_log0.delete(); d_log1.delete();
      m_ovr[0] = 0; m_ovr[1] = 0; d_ovr0 = 0; d_ovr1 = 0;
   endtask

   task automatic send_bytes(input logic [7:0] bytes[$], input logic a);
      foreach (bytes[i]) step(1'b1, bytes[i], a, 1'b0);
   endtask

   task automatic drain();
      for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      clear_logs();
      step(1'b0, 8'h00, 1'b0, 1'b1);
      step(1'b1, 8'h90, 1'b1, 1'b1);
      checks++;
      if ({v0, o0, c0, a0, b0} !== 24'h0) begin
         errors++; $display("FAIL reset_u0 got v%b o%b %h %h %h exp all 0", v0, o0, c0, a0, b0);
      end
      checks++;
      if ({v1, o1, c1, a1, b1} !== 24'h0) begin
         errors++; $display("FAIL reset_u1 got v%b o%b %h %h %h exp all 0", v1, o1, c1, a1, b1);
      end
      step(1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic test_note_on();
      clear_logs();
      step(1'b1, 8'h90, 1'b0, 1'b0);
      step(1'b1, 8'h3C, 1'b0, 1'b0);
      checks++;
      if (v0 !== 1'b0) begin errors++; $display("FAIL note_early_valid got %b exp 0", v0); end
      step(1'b1, 8'h64, 1'b0, 1'b0);
      checks++;
      if (v0 !== 1'b1 || {c0, a0, b0} !== {8'h90, 7'h3C, 7'h64}) begin
         errors++; $display("FAIL note_event got v%b %h %h %h exp v1 90 3c 64", v0, c0, a0, b0);
      end
      checks++;
      if (v1 !== 1'b0) begin errors++; $display("FAIL note_filtered got %b exp 0", v1); end
      step(1'b0, 8'h00, 1'b0, 1'b0);
      checks++;
      if (v0 !== 1'b1) begin errors++; $display("FAIL note_hold got %b exp 1", v0); end
      step(1'b0, 8'h00, 1'b1, 1'b0);
      checks++;
      if (v0 !== 1'b0) begin errors++; $display("FAIL note_ack_clear got %b exp 0", v0); end
      checks++;
      if (d_log0.size() != 1) begin errors++; $display("FAIL note_count got %0d exp 1", d_log0.size()); end
   endtask

   task automatic test_running_status();
      clear_logs();
      send_bytes('{8'h91, 8'h40, 8'h50, 8'h42, 8'h00}, 1'b1);
      drain();
      checks++;
      if (d_log0.size() != 2) begin
         errors++; $display("FAIL rs_count got %0d exp 2", d_log0.size());
      end else begin
         checks++;
         if (d_log0[0] !== {8'h91, 7'h40, 7'h50} || d_log0[1] !== {8'h81, 7'h42, 7'h00}) begin
            errors++; $display("FAIL rs_events got %h %h exp {91,40,50} {81,42,00}", d_log0[0], d_log0[1]);
         end
      end
      checks++;
      if (d_log1.size() != m_log1.size()) begin
         errors++; $display("FAIL rs_u1_count got %0d exp %0d", d_log1.size(), m_log1.size());
      end
   endtask

   task automatic test_prog_sysex();
      clear_logs();
      send_bytes('{8'hC2, 8'h05, 8'h07, 8'hF0, 8'h11, 8'h22, 8'hF7, 8'h33}, 1'b1);
      drain();
      checks++;
      if (d_log0.size() != 2) begin
         errors++; $display("FAIL pc_count got %0d exp 2", d_log0.size());
      end else begin
         checks++;
         if (d_log0[0] !== {8'hC2, 7'h05, 7'h00} || d_log0[1] !== {8'hC2, 7'h07, 7'h00}) begin
            errors++; $display("FAIL pc_events got %h %h exp {c2,05,00} {c2,07,00}", d_log0[0], d_log0[1]);
         end
      end
   endtask

   task automatic test_realtime();
      clear_logs();
      send_bytes('{8'h80, 8'hF8, 8'h3C, 8'hFE, 8'h00}, 1'b1);
      drain();
      checks++;
      if (d_log0.size() != 1) begin
         errors++; $display("FAIL rt_count got %0d exp 1", d_log0.size());
      end else begin
         checks++;
         if (d_log0[0] !== {8'h80, 7'h3C, 7'h00}) begin
            errors++; $display("FAIL rt_event got %h exp {80,3c,00}", d_log0[0]);
         end
      end
   endtask

   task automatic test_backpressure();
      clear_logs();
      send_bytes('{8'h93, 8'h3C, 8'h40, 8'h3D, 8'h41}, 1'b0);
      checks++;
      if (o0 !== 1'b1 || o1 !== 1'b1) begin
         errors++; $display("FAIL bp_overrun got %b %b exp 1 1", o0, o1);
      end
      checks++;
      if (v0 !== 1'b1 || {c0, a0, b0} !== {8'h93, 7'h3C, 7'h40}) begin
         errors++; $display("FAIL bp_held got v%b %h %h %h exp v1 93 3c 40", v0, c0, a0, b0);
      end
      step(1'b0, 8'h00, 1'b0, 1'b0);
      checks++;
      if (o0 !== 1'b0) begin errors++; $display("FAIL bp_pulse_width got %b exp 0", o0); end
      drain();
      checks++;
      if (d_ovr0 != 1 || d_ovr1 != m_ovr[1]) begin
         errors++; $display("FAIL bp_ovr_count got %0d %0d exp 1 %0d", d_ovr0, d_ovr1, m_ovr[1]);
      end
      checks++;
      if (d_log0.size() != 1 || d_log1.size() != 1) begin
         errors++; $display("FAIL bp_count got %0d %0d exp 1 1", d_log0.size(), d_log1.size());
      end
   endtask

   task automatic test_reset_mid_filter();
      clear_logs();
      send_bytes('{8'h90, 8'h3C, 8'h40, 8'h3D}, 1'b0);
      step(1'b1, 8'h41, 1'b1, 1'b1);
      checks++;
      if ({v0, c0, a0, b0} !== 23'h0) begin
         errors++; $display("FAIL rstmid_clear got v%b %h %h %h exp all 0", v0, c0, a0, b0);
      end
      step(1'b1, 8'h40, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      checks++;
      if (v0 !== 1'b0 || d_log0.size() != 0) begin
         errors++; $display("FAIL rstmid_noevent got v%b n%0d exp v0 n0", v0, d_log0.size());
      end
      send_bytes('{8'h92, 8'h3C, 8'h40, 8'h93, 8'h3C, 8'h40}, 1'b1);
      drain();
      checks++;
      if (d_log1.size() != 1) begin
         errors++; $display("FAIL filter_count got %0d exp 1", d_log1.size());
      end else begin
         checks++;
         if (d_log1[0] !== {8'h93, 7'h3C, 7'h40}) begin
            errors++; $display("FAIL filter_event got %h exp {93,3c,40}", d_log1[0]);
         end
      end
      checks++;
      if (d_log0.size() != 2) begin errors++; $display("FAIL nofilter_count got %0d exp 2", d_log0.size()); end
   endtask

   task automatic test_random();
      logic [7:0] d;
      logic       v, a, r;
      int         sel;
      clear_logs();
      for (int n = 0; n < 3000; n++) begin
         sel = int'($urandom_range(99));
         if (sel < 55)      d = 8'($urandom_range(127));
         else if (sel < 80) d = {4'($urandom_range(14, 8)), 4'($urandom_range(4))};
         else if (sel < 88) d = 8'hF0 + 8'($urandom_range(7));
         else               d = 8'hF8 + 8'($urandom_range(7));
         v = ($urandom_range(3) != 0);
         a = ($urandom_range(3) == 0);
         r = ($urandom_range(299) == 0);
         step(v, d, a, r);
         checks++;
         if (v0 !== m_hv[0] || o0 !== m_op[0] || (m_hv[0] && {c0, a0, b0} !== m_hold[0])) begin
            errors++; $display("FAIL rand_u0 n%0d got v%b o%b %h exp v%b o%b %h", n, v0, o0, {c0, a0, b0}, m_hv[0], m_op[0], m_hold[0]);
         end
         checks++;
         if (v1 !== m_hv[1] || o1 !== m_op[1] || (m_hv[1] && {c1, a1, b1} !== m_hold[1])) begin
            errors++; $display("FAIL rand_u1 n%0d got v%b o%b %h exp v%b o%b %h", n, v1, o1, {c1, a1, b1}, m_hv[1], m_op[1], m_hold[1]);
         end
      end
      drain();
      checks++;
      if (d_log0 != m_log0 || d_log1 != m_log1) begin
         errors++; $display("FAIL rand_logs got %0d %0d exp %0d %0d", d_log0.size(), d_log1.size(), m_log0.size(), m_log1.size());
      end
      checks++;
      if (d_ovr0 != m_ovr[0] || d_ovr1 != m_ovr[1]) begin
         errors++; $display("FAIL rand_ovr got %0d %0d exp %0d %0d", d_ovr0, d_ovr1, m_ovr[0], m_ovr[1]);
      end
   endtask

   initial begin
      test_reset();
      test_note_on();
      test_running_status();
      test_prog_sysex();
      test_realtime();
      test_backpressure();
      test_reset_mid_filter();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
